// File: rtl/mul_iter_unit.sv
// Iterative unsigned multiplier: repeated addition (MODE 0) or shift-and-add (MODE 1).
// A three-state FSM sequences a start/busy/done handshake around a 2*WIDTH product register.
module mul_iter_unit #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int SWAP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_product;
    logic [WIDTH-1:0] r_cnt;
    logic             w_swap;
    logic [WIDTH-1:0] w_load_a;
    logic [WIDTH-1:0] w_load_b;
    logic             w_accept;

    // Counting down the smaller operand bounds the repeated-addition latency.
    assign w_swap   = (MODE == 0) && (SWAP != 0) && (b_in > a_in);
    assign w_load_a = w_swap ? b_in : a_in;
    assign w_load_b = w_swap ? a_in : b_in;
    assign w_accept = (r_state == S_IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == '0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= {{WIDTH{1'b0}}, w_load_a};
            r_cnt     <= w_load_b;
            r_product <= '0;
        end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
            if (MODE == 0) begin
                r_product <= r_product + r_acc;
                r_cnt     <= r_cnt - 1'b1;
            end else begin
                if (r_cnt[0]) begin
                    r_product <= r_product + r_acc;
                end
                r_acc <= r_acc << 1;
                r_cnt <= r_cnt >> 1;
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit: three instances cover MODE0/SWAP1, MODE0/SWAP0 and MODE1.
// Expected products and cycle counts are hand-computed constants.
module tb_mul_iter_unit;

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [2:0]  start_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [31:0] prod_v [3];

    int total;
    int bad;

    mul_iter_unit #(.WIDTH(16), .MODE(0), .SWAP(1)) u_m0s1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0])
    );

    mul_iter_unit #(.WIDTH(16), .MODE(0), .SWAP(0)) u_m0s0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1])
    );

    mul_iter_unit #(.WIDTH(16), .MODE(1), .SWAP(1)) u_m1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a_in(a_in), .b_in(b_in),
        .busy(busy_v[2]), .done(done_v[2]), .product(prod_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse, operands scrambled after accept, then latency/product/hold checks.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p, input int exp_n, input bit chk_n,
                          input string tag);
        int edges;
        int run_cyc;
        @(negedge clk);
        a_in       = a;
        b_in       = b;
        start_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        a_in       = ~a;
        b_in       = ~b;
        edges      = 0;
        run_cyc    = 0;
        while (!done_v[k] && edges < 2000) begin
            if (busy_v[k]) run_cyc++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(done_v[k]), 64'd1);
        if (chk_n) begin
            check({tag, "_edges"}, 64'(edges), 64'(exp_n + 1));
            check({tag, "_run_cycles"}, 64'(run_cyc), 64'(exp_n + 1));
        end
        check({tag, "_product"}, 64'(prod_v[k]), 64'(exp_p));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done_v[k]), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy_v[k]), 64'd0);
        check({tag, "_hold"}, 64'(prod_v[k]), 64'(exp_p));
    endtask

    initial begin
        int cyc;
        int dones;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start_v = 3'b000;
        a_in    = 16'd0;
        b_in    = 16'd0;

        // Reset overrides a pending start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b1;
        a_in       = 16'd9;
        b_in       = 16'd9;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        check("rst_product", 64'(prod_v[0]), 64'd0);
        start_v[0] = 1'b0;
        rst        = 1'b0;

        run_op(0, 16'd5,    16'd3,    32'd15,   3,    1'b1, "m0s1_5x3");
        run_op(0, 16'd3,    16'd1000, 32'd3000, 3,    1'b1, "m0s1_3x1000");
        run_op(0, 16'd1000, 16'd3,    32'd3000, 3,    1'b1, "m0s1_1000x3");
        run_op(1, 16'd3,    16'd1000, 32'd3000, 1000, 1'b1, "m0s0_3x1000");
        run_op(1, 16'd1000, 16'd3,    32'd3000, 3,    1'b1, "m0s0_1000x3");
        run_op(0, 16'd0,    16'hFFFF, 32'd0,    0,    1'b1, "m0s1_0xffff");
        run_op(1, 16'hFFFF, 16'd0,    32'd0,    0,    1'b1, "m0s0_ffffx0");
        run_op(2, 16'hFFFF, 16'd0,    32'd0,    0,    1'b1, "m1_ffffx0");
        run_op(2, 16'd0,    16'hFFFF, 32'd0,    16,   1'b0, "m1_0xffff");
        run_op(2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 1'b1, "m1_ffffxffff");
        run_op(2, 16'h1234, 16'd5,    32'h00005B04, 3,  1'b1, "m1_1234x5");
        run_op(0, 16'd7,    16'd7,    32'd49,   7,    1'b1, "m0s1_7x7");

        // Start pulsed mid-run with new operands must not disturb the operation.
        @(negedge clk);
        a_in       = 16'd100;
        b_in       = 16'd50;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        a_in       = 16'd7;
        b_in       = 16'd7;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (!done_v[0] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("midstart_done_seen", 64'(done_v[0]), 64'd1);
        check("midstart_product", 64'(prod_v[0]), 64'd5000);
        @(negedge clk);

        // Reset mid-run aborts with no done pulse.
        a_in       = 16'd100;
        b_in       = 16'd50;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_done", 64'(done_v[0]), 64'd0);
        check("abort_product", 64'(prod_v[0]), 64'd0);
        rst   = 1'b0;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_v[0]) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        // Start held high: 2x2 gives N=2, so a done pulse every N+3 = 5 cycles.
        a_in       = 16'd2;
        b_in       = 16'd2;
        start_v[0] = 1'b1;
        for (int p = 0; p < 4; p++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done_v[0] && cyc < 50);
            check($sformatf("b2b_done_%0d", p), 64'(done_v[0]), 64'd1);
            check($sformatf("b2b_product_%0d", p), 64'(prod_v[0]), 64'd4);
            if (p > 0) check($sformatf("b2b_period_%0d", p), 64'(cyc), 64'd5);
        end
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_idle", 64'(busy_v[0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
